// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_pkg
// Brief    : Shared FSM state type and width helpers for the sequential sqrt.
// Revision : 1.0 - initial release
// ============================================================================
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Result width: half the radicand integer bits (rounded up) plus fraction bits.
  function automatic int out_w(input int in_w, input int frac_w);
    return (in_w + 1) / 2 + frac_w;
  endfunction

  function automatic int iter(input int in_w, input int frac_w, input int bpc);
    return out_w(in_w, frac_w) / bpc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_fixed_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_fixed_seq_if
// Brief    : Radicand-in / root-out valid-ready handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sqrt_fixed_seq_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_root;
  logic             out_exact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_root, out_exact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_root, out_exact
  );

endinterface
`default_nettype wire

// File: rtl/sqrt_step.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_step
// Brief    : One restoring digit-by-digit square-root step (one result bit).
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_step #(
  parameter int OUT_W = 16
) (
  input  wire logic [OUT_W+1:0] rem_i,
  input  wire logic [OUT_W-1:0] q_i,
  input  wire logic [1:0]       bits_i,
  output logic      [OUT_W+1:0] rem_o,
  output logic      [OUT_W-1:0] q_o
);

  logic [OUT_W+1:0] w_sh;
  logic [OUT_W+1:0] w_t;
  logic             w_ge;

  // The partial remainder never exceeds 2*Q, so its top two bits are zero on
  // entry; if they were set the shifted value would certainly exceed T.
  always_comb begin
    w_sh  = {rem_i[OUT_W-1:0], bits_i};
    w_t   = {q_i, 2'b01};
    w_ge  = (|rem_i[OUT_W+1:OUT_W]) || (w_sh >= w_t);
    rem_o = w_ge ? (w_sh - w_t) : w_sh;
    q_o   = {q_i[OUT_W-2:0], w_ge};
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_fixed_seq.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_fixed_seq
// Brief    : Sequential fixed-point sqrt, BPC root bits per cycle, one op in
//            flight. Define SQRT_ROUND_EN for round-half-up via a ROUND state.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_fixed_seq
  import sqrt_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int BPC    = 1
) (
  input wire logic         clock,
  input wire logic         reset,
  sqrt_fixed_seq_if.slave  bus
);

  localparam int OUT_W = out_w(IN_W, FRAC_W);
  localparam int ITER  = iter(IN_W, FRAC_W, BPC);
  localparam int RAD_W = 2 * OUT_W;
  localparam int REM_W = OUT_W + 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  if (((OUT_W % BPC) != 0) || !((BPC == 1) || (BPC == 2) || (BPC == 4))) begin : g_bpc_check
    $fatal(1, "sqrt_fixed_seq: BPC must be 1, 2 or 4 and divide OUT_W");
  end

  state_t           state_q, state_d;
  logic [RAD_W-1:0] r_q,     r_d;
  logic [REM_W-1:0] rem_q,   rem_d;
  logic [OUT_W-1:0] q_q,     q_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [RAD_W-1:0] w_r_load;
  logic [REM_W-1:0] w_rem [0:BPC];
  logic [OUT_W-1:0] w_q   [0:BPC];

  assign w_r_load = RAD_W'(bus.in_data) << (2 * FRAC_W);

  assign w_rem[0] = rem_q;
  assign w_q[0]   = q_q;

  // Radicand bit pairs are consumed MSB first, one pair per chained step.
  for (genvar k = 0; k < BPC; k++) begin : g_step
    sqrt_step #(
      .OUT_W (OUT_W)
    ) u_step (
      .rem_i  (w_rem[k]),
      .q_i    (w_q[k]),
      .bits_i (r_q[RAD_W-1-2*k -: 2]),
      .rem_o  (w_rem[k+1]),
      .q_o    (w_q[k+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          r_d     = w_r_load;
          rem_d   = '0;
          q_d     = '0;
          cnt_d   = CNT_W'(ITER - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        r_d   = r_q << (2 * BPC);
        rem_d = w_rem[BPC];
        q_d   = w_q[BPC];
        if (cnt_q == '0) begin
`ifdef SQRT_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ROUND: begin
`ifdef SQRT_ROUND_EN
        // REM > Q means the true root is at least Q + 0.5.
        if (rem_q > {2'b00, q_q}) begin
          q_d = (&q_q) ? q_q : (q_q + OUT_W'(1));
        end
`endif
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_root  = q_q;
  assign bus.out_exact = (state_q == DONE) && (rem_q == '0);

endmodule
`default_nettype wire
